// File: rtl/psum_fb_buf.sv
// psum_fb_buf
// Partial-sum feedback buffer for the 3x3 conv kernel. It feeds the previous
// pass's partial sum of each output pixel to the psum adder tree and captures
// the adder result back into the buffer. Once all input-channel passes of a
// tile are done, it drains the finished sums downstream with valid/ready.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle pulse, latches cfg_len/cfg_passes when idle
//   cfg_len              pixels per pass, 1..DEPTH
//   cfg_passes           input-channel passes, 0 behaves as 1
//   busy                 tile in progress (accepted start until done)
//   acc_rdy              a pe_vld beat is accepted this cycle
//   pe_vld               PE data valid at the adder input
//   psum_in              feedback operand to the adder, aligned with pe_vld
//   psum_out             adder result, valid LAT cycles after an accepted beat
//   out_valid/out_ready  drain handshake
//   out_data, out_last   drained sum and last-pixel marker
//   done                 one-cycle pulse after the last drain beat
//   err                  sticky: pe_vld while not ready, or illegal cfg_len
module psum_fb_buf #(
  parameter int DWIDTH = 25,
  parameter int DEPTH  = 64,
  parameter int PWIDTH = 8,
  parameter int LAT    = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [AW:0]       cfg_len,
  input  logic [PWIDTH-1:0] cfg_passes,
  output logic              busy,
  output logic              acc_rdy,
  input  logic              pe_vld,
  output logic [DWIDTH-1:0] psum_in,
  input  logic [DWIDTH-1:0] psum_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [AW:0]       ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [PWIDTH-1:0] PONE    = {{(PWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]       DEPTH_C = DEPTH[AW:0];

  logic [1:0]        state_q, state_d;
  logic [AW:0]       len_q, len_d;
  logic [PWIDTH-1:0] passes_q, passes_d;
  logic [PWIDTH-1:0] pass_q, pass_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       dr_ptr_q, dr_ptr_d;
  logic [LAT-1:0]    vld_q, vld_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Buffer contents are never reset: pass 0 does not read them.
  logic [DWIDTH-1:0] mem [DEPTH];

  logic        acc_fire;
  logic        wr_en;
  logic        cfg_ok;
  logic [AW:0] wr_inc;
  logic        writes_done;

  assign acc_rdy   = (state_q == S_ACC);
  assign acc_fire  = pe_vld & acc_rdy;
  assign wr_en     = vld_q[LAT-1];
  assign wr_inc    = {{AW{1'b0}}, wr_en};
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= DEPTH_C);
  // Counting the write landing this cycle lets FLUSH leave exactly LAT cycles
  // after the last beat; the next read sees that write because it is a later cycle.
  assign writes_done = ((wr_ptr_q + wr_inc) == len_q);

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = out_valid && (dr_ptr_q == len_q - ONE);
  assign out_data  = out_valid ? mem[dr_ptr_q[AW-1:0]] : '0;
  assign psum_in   = (acc_fire && (pass_q != '0)) ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign done      = done_q;
  assign err       = err_q;

  // Accepted-beat strobe delayed to line up with psum_out.
  assign vld_d[0] = acc_fire;
  for (genvar gi = 1; gi < LAT; gi++) begin : g_vld
    assign vld_d[gi] = vld_q[gi-1];
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    passes_d = passes_q;
    pass_d   = pass_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q + wr_inc;
    dr_ptr_d = dr_ptr_q;
    done_d   = 1'b0;
    err_d    = err_q | (pe_vld & ~acc_rdy);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            len_d    = cfg_len;
            passes_d = (cfg_passes == '0) ? PONE : cfg_passes;
            pass_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = S_ACC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACC: begin
        if (acc_fire) begin
          rd_ptr_d = rd_ptr_q + ONE;
          if (rd_ptr_q == len_q - ONE) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (writes_done) begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          if (pass_q + PONE < passes_q) begin
            pass_d  = pass_q + PONE;
            state_d = S_ACC;
          end else begin
            dr_ptr_d = '0;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          dr_ptr_d = dr_ptr_q + ONE;
          if (out_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      passes_q <= '0;
      pass_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      dr_ptr_q <= '0;
      vld_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      dr_ptr_q <= dr_ptr_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= psum_out;
    end
  end

endmodule

// File: tb/tb_psum_fb_buf.sv
// Bench for psum_fb_buf: models the adder (psum_out = psum_in + PE data, LAT
// cycles later) and checks every cycle against per-pixel running sums.
module tb_psum_fb_buf;

  localparam int DW  = 25;
  localparam int LAT = 2;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [6:0]    cfg_len;
  logic [7:0]    cfg_passes;
  logic          busy;
  logic          acc_rdy;
  logic          pe_vld;
  logic [DW-1:0] psum_in;
  logic [DW-1:0] psum_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic          err;

  psum_fb_buf dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
    .busy(busy), .acc_rdy(acc_rdy), .pe_vld(pe_vld), .psum_in(psum_in), .psum_out(psum_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // PE data per pass and pixel for the current tile
  logic [DW-1:0] data_t [8][64];
  int tile_len = 1;
  int tile_np = 1;
  int tile_base = 0;

  // adder / PE model
  int acc_cnt = 0;
  logic [DW-1:0] pipe0 = '0;
  logic [DW-1:0] pipe1 = '0;
  assign psum_out = pipe1;

  always @(posedge clk) begin
    if (pe_vld && acc_rdy) begin
      pipe0 <= psum_in + data_t[((acc_cnt - tile_base) / tile_len) % 8][(acc_cnt - tile_base) % tile_len];
      acc_cnt <= acc_cnt + 1;
    end else begin
      pipe0 <= 25'h1A5A5A5;
    end
    pipe1 <= pipe0;
  end

  // monitor state
  int chk_beat;
  int dr_k;
  bit tile_done;
  bit err_model;
  bit done_pend;
  bit gap_on;
  int gap_cnt;
  logic [DW-1:0] q_in[$];
  logic [DW-1:0] q_out[$];
  logic q_last[$];
  int pat[4] = '{1, 0, 0, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sum of passes 0..p-1 for pixel i, wrapping at DW bits
  function automatic logic [DW-1:0] exp_in(input int p, input int i);
    logic [DW-1:0] s;
    s = '0;
    for (int q = 0; q < p; q++) s = s + data_t[q][i];
    return s;
  endfunction

  task automatic monitor();
    int p;
    int i;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        err_model = 1'b0;
        done_pend = 1'b0;
        gap_on = 1'b0;
        continue;
      end
      chk("err", 32'(err), 32'(err_model));
      if (pe_vld && !acc_rdy) err_model = 1'b1;
      if (start && !busy && (cfg_len == 0 || cfg_len > 64)) err_model = 1'b1;

      chk("done", 32'(done), 32'(done_pend));
      if (done) begin
        tile_done = 1'b1;
        chk("busy_at_done", 32'(busy), 32'(0));
      end
      done_pend = 1'b0;

      if (gap_on) begin
        if (!acc_rdy) gap_cnt++;
        else begin
          chk("flush_gap", 32'(gap_cnt), 32'(LAT));
          gap_on = 1'b0;
        end
      end

      if (pe_vld && acc_rdy) begin
        p = chk_beat / tile_len;
        i = chk_beat % tile_len;
        if (chk_beat >= tile_len * tile_np) begin
          chk("extra_accept", 32'(chk_beat), 32'(tile_len * tile_np - 1));
        end else begin
          chk("psum_in", 32'(psum_in), 32'(exp_in(p, i)));
        end
        q_in.push_back(psum_in);
        chk_beat++;
        if (i == tile_len - 1 && p < tile_np - 1) begin
          gap_on = 1'b1;
          gap_cnt = 0;
        end
      end else begin
        chk("psum_in_idle", 32'(psum_in), 32'(0));
      end

      if (out_valid) begin
        if (dr_k >= tile_len) begin
          chk("extra_drain", 32'(dr_k), 32'(tile_len - 1));
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_in(tile_np, dr_k)));
          chk("out_last", 32'(out_last), 32'(dr_k == tile_len - 1));
        end
        if (out_ready) begin
          q_out.push_back(out_data);
          q_last.push_back(out_last);
          if (dr_k == tile_len - 1) done_pend = 1'b1;
          dr_k++;
        end
      end else begin
        chk("out_last_idle", 32'(out_last), 32'(0));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_acc_rdy"}, 32'(acc_rdy), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_last"}, 32'(out_last), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
    chk({tag, "_psum_in"}, 32'(psum_in), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
  endtask

  task automatic begin_tile(input int len, input int np_cfg);
    tile_len = len;
    tile_np = (np_cfg == 0) ? 1 : np_cfg;
    tile_base = acc_cnt;
    chk_beat = 0;
    dr_k = 0;
    tile_done = 1'b0;
    gap_on = 1'b0;
    q_in.delete();
    q_out.delete();
    q_last.delete();
    start = 1'b1;
    cfg_len = 7'(len);
    cfg_passes = 8'(np_cfg);
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
  endtask

  // rdy_mode: 0 random, 1 pattern 1,0,0,1, 2 always ready
  task automatic run_tile(input int len, input int np_cfg, input int rdy_mode, input bit abuse);
    int total;
    int k;
    begin_tile(len, np_cfg);
    total = tile_len * tile_np;
    k = 0;
    for (int cyc = 0; cyc < 4000 && !tile_done; cyc++) begin
      pe_vld = 1'b0;
      start = 1'b0;
      if (acc_cnt - tile_base < total) begin
        if (acc_rdy) pe_vld = ($urandom % 4 != 0);
        else if (abuse && busy && !out_valid) pe_vld = 1'b1;
      end
      if (abuse && busy && ($urandom % 8 == 0)) begin
        start = 1'b1;
        cfg_len = 7'($urandom_range(1, 64));
        cfg_passes = 8'($urandom);
      end
      case (rdy_mode)
        0: out_ready = ($urandom % 2 == 0);
        1: begin
          out_ready = pat[k % 4][0];
          if (out_valid) k++;
        end
        default: out_ready = 1'b1;
      endcase
      tick();
    end
    pe_vld = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    chk("tile_completed", 32'(tile_done), 32'(1));
    chk("drain_count", 32'(q_out.size()), 32'(len));
    $display("tile len=%0d passes=%0d rdy_mode=%0d abuse=%0d beats=%0d drained=%0d",
             len, np_cfg, rdy_mode, abuse, acc_cnt - tile_base, q_out.size());
  endtask

  task automatic fill_random(input int np);
    for (int p = 0; p < np; p++)
      for (int i = 0; i < 64; i++) data_t[p][i] = DW'($urandom);
  endtask

  task automatic fill_const(input int v);
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < 64; i++) data_t[p][i] = DW'(v);
  endtask

  initial begin
    int tl;
    int tp;
    rstn = 1'b0;
    start = 1'b0;
    cfg_len = '0;
    cfg_passes = '0;
    pe_vld = 1'b0;
    out_ready = 1'b0;
    fill_const(0);
    fork
      monitor();
    join_none
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // len=4, one pass: drain returns the adder outputs unchanged
    fill_const(0);
    data_t[0][0] = 25'd10; data_t[0][1] = 25'd20; data_t[0][2] = 25'd30; data_t[0][3] = 25'd40;
    run_tile(4, 1, 2, 1'b0);
    if (q_out.size() == 4) begin
      chk("t1_d0", 32'(q_out[0]), 32'd10);
      chk("t1_d1", 32'(q_out[1]), 32'd20);
      chk("t1_d2", 32'(q_out[2]), 32'd30);
      chk("t1_d3", 32'(q_out[3]), 32'd40);
      chk("t1_last2", 32'(q_last[2]), 32'd0);
      chk("t1_last3", 32'(q_last[3]), 32'd1);
    end
    if (q_in.size() == 4) chk("t1_in3", 32'(q_in[3]), 32'd0);

    // len=3, three passes of +5
    fill_const(5);
    run_tile(3, 3, 0, 1'b0);
    if (q_in.size() == 9) begin
      chk("t2_in_p0", 32'(q_in[2]), 32'd0);
      chk("t2_in_p1", 32'(q_in[4]), 32'd5);
      chk("t2_in_p2", 32'(q_in[8]), 32'd10);
    end
    if (q_out.size() == 3) chk("t2_out", 32'(q_out[1]), 32'd15);

    // len=1, four passes of +7: read-after-write corner
    fill_const(7);
    run_tile(1, 4, 2, 1'b0);
    if (q_in.size() == 4) chk("t3_in_p3", 32'(q_in[3]), 32'd21);
    if (q_out.size() == 1) chk("t3_out", 32'(q_out[0]), 32'd28);

    // stalled drain, full-depth tile, passes=0 treated as one pass
    fill_random(3);
    run_tile(6, 3, 1, 1'b0);
    fill_random(2);
    run_tile(64, 2, 2, 1'b0);
    fill_random(1);
    run_tile(5, 0, 0, 1'b0);

    for (int t = 0; t < 5; t++) begin
      tl = $urandom_range(1, 64);
      tp = $urandom_range(1, 6);
      fill_random(tp);
      run_tile(tl, tp, t % 3, 1'b0);
    end

    // pe_vld during FLUSH and start while busy: err set, result intact
    fill_random(3);
    run_tile(5, 3, 0, 1'b1);
    chk("abuse_err", 32'(err), 32'(1));

    // reset in the middle of pass 2 of a len=8 tile
    fill_random(3);
    begin_tile(8, 3);
    for (int cyc = 0; cyc < 200 && (acc_cnt - tile_base) < 11; cyc++) begin
      pe_vld = acc_rdy;
      tick();
    end
    pe_vld = 1'b0;
    chk("mid_reset_reached", 32'((acc_cnt - tile_base) >= 11), 32'(1));
    rstn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    fill_random(1);
    run_tile(2, 1, 0, 1'b0);
    chk("post_reset_err", 32'(err), 32'(0));

    // illegal lengths
    start = 1'b1;
    cfg_len = 7'd0;
    cfg_passes = 8'd1;
    tick();
    start = 1'b0;
    chk("len0_busy", 32'(busy), 32'(0));
    chk("len0_err", 32'(err), 32'(1));
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start = 1'b1;
    cfg_len = 7'd65;
    tick();
    start = 1'b0;
    chk("len65_busy", 32'(busy), 32'(0));
    chk("len65_err", 32'(err), 32'(1));
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
